// File: rtl/nibble_sorter_pkg.sv
// Shared types and constants for the nibble stream sorter.
package nibble_sorter_pkg;

   typedef logic [3:0] nibble_t;

   localparam int FRAME_LEN = 4;

   typedef enum logic {
      LOAD  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   // Per-slot update request issued by the top each cycle.
   typedef enum logic [1:0] {
      SLOT_IDLE     = 2'd0,
      SLOT_INSERT   = 2'd1,
      SLOT_SHIFT_DN = 2'd2,
      SLOT_SHIFT_UP = 2'd3
   } slot_mode_e;

endpackage

// File: rtl/nibble_stream_sorter_sort_slot.sv
// One slot of the insertion buffer: holds a nibble and chooses hold,
// take-input, or take-neighbour from its own compare against the incoming nibble.
module sort_slot
   import nibble_sorter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  slot_mode_e mode_i,
   input  logic       valid_i,
   input  nibble_t    din_i,
   input  nibble_t    lower_i,
   input  logic       lower_gt_i,
   input  nibble_t    upper_i,
   output logic       gt_o,
   output nibble_t    q_o,
   output nibble_t    d_o
);

   nibble_t q_q;
   nibble_t d_s;
   logic    gt_s;

   // An empty slot counts as larger than anything so new data lands in it.
   always_comb begin
      gt_s = (!valid_i) || (q_q > din_i);
      d_s  = q_q;
      case (mode_i)
         SLOT_INSERT: begin
            if (lower_gt_i) begin
               d_s = lower_i;
            end else if (gt_s) begin
               d_s = din_i;
            end else begin
               d_s = q_q;
            end
         end
         SLOT_SHIFT_DN: d_s = upper_i;
         SLOT_SHIFT_UP: d_s = lower_i;
         default:       d_s = q_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= 4'd0;
      end else begin
         q_q <= d_s;
      end
   end

   assign gt_o = gt_s;
   assign q_o  = q_q;
   assign d_o  = d_s;

endmodule

// File: rtl/nibble_stream_sorter.sv
// Four-nibble frame sorter: insertion-sorts a frame on load, then drains it.
// Define NIBBLE_SORTER_DESC_EN to drain largest-first instead of smallest-first.
module nibble_stream_sorter
   import nibble_sorter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [3:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_word,
   output logic [2:0]  fill
);

   state_e     state_q;
   logic [2:0] fill_q;
   logic       in_ready_q;
   logic       out_valid_q;
   logic [15:0] out_word_q;

   nibble_t [FRAME_LEN-1:0] slot_q;
   nibble_t [FRAME_LEN-1:0] slot_d;
   nibble_t [FRAME_LEN-1:0] lower_s;
   nibble_t [FRAME_LEN-1:0] upper_s;
   logic    [FRAME_LEN-1:0] gt_s;
   logic    [FRAME_LEN-1:0] lower_gt_s;
   logic    [FRAME_LEN-1:0] valid_s;

   logic       accept_s;
   logic       drain_s;
   slot_mode_e mode_s;

   assign accept_s = (state_q == LOAD) && in_ready_q && in_valid;
   assign drain_s  = (state_q == DRAIN) && out_valid_q && out_ready;

   always_comb begin
      mode_s = SLOT_IDLE;
      if (accept_s) begin
         mode_s = SLOT_INSERT;
      end else if (drain_s) begin
`ifdef NIBBLE_SORTER_DESC_EN
         mode_s = SLOT_SHIFT_UP;
`else
         mode_s = SLOT_SHIFT_DN;
`endif
      end else begin
         mode_s = SLOT_IDLE;
      end
   end

   // Slot 0 is the smallest; draining shifts zeros in from the far end.
   for (genvar i = 0; i < FRAME_LEN; i++) begin : g_slot
      assign valid_s[i] = (3'(i) < fill_q);

      if (i == 0) begin : g_lo_edge
         assign lower_s[i]    = 4'd0;
         assign lower_gt_s[i] = 1'b0;
      end else begin : g_lo_link
         assign lower_s[i]    = slot_q[i-1];
         assign lower_gt_s[i] = gt_s[i-1];
      end

      if (i == FRAME_LEN-1) begin : g_hi_edge
         assign upper_s[i] = 4'd0;
      end else begin : g_hi_link
         assign upper_s[i] = slot_q[i+1];
      end

      sort_slot u_slot (
         .clk        (clk),
         .rst        (rst),
         .mode_i     (mode_s),
         .valid_i    (valid_s[i]),
         .din_i      (in_data),
         .lower_i    (lower_s[i]),
         .lower_gt_i (lower_gt_s[i]),
         .upper_i    (upper_s[i]),
         .gt_o       (gt_s[i]),
         .q_o        (slot_q[i]),
         .d_o        (slot_d[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LOAD;
         fill_q      <= 3'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_word_q  <= 16'd0;
      end else begin
         case (state_q)
            LOAD: begin
               if (accept_s) begin
                  fill_q <= fill_q + 3'd1;
                  if (fill_q == 3'(FRAME_LEN-1)) begin
                     state_q     <= DRAIN;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     out_word_q  <= slot_d;
                  end
               end
            end
            DRAIN: begin
               if (drain_s) begin
                  fill_q <= fill_q - 3'd1;
                  if (fill_q == 3'd1) begin
                     state_q     <= LOAD;
                     in_ready_q  <= 1'b1;
                     out_valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q     <= LOAD;
               fill_q      <= 3'd0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_word  = out_word_q;
   assign fill      = fill_q;
`ifdef NIBBLE_SORTER_DESC_EN
   assign out_data  = slot_q[FRAME_LEN-1];
`else
   assign out_data  = slot_q[0];
`endif

endmodule

// File: tb/tb_nibble_stream_sorter.sv
// Directed self-checking bench for nibble_stream_sorter (either drain order).
module tb_nibble_stream_sorter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_word;
   logic [2:0]  fill;

   int n_checks = 0;
   int n_pass   = 0;

   nibble_stream_sorter dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .fill      (fill)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // k-th drained nibble given the sorted frame word (largest in [15:12]).
   function automatic logic [3:0] pick(input logic [15:0] w, input int k);
`ifdef NIBBLE_SORTER_DESC_EN
      return w[4*(3-k) +: 4];
`else
      return w[4*k +: 4];
`endif
   endfunction

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic feed4(input logic [15:0] beats);
      for (int k = 0; k < 4; k++) begin
         in_data  = beats[4*(3-k) +: 4];
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      n_checks++; if (fill !== 3'd0) $display("FAIL reset_fill got %0d want 0", fill); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
      n_checks++; if (out_data !== 4'd0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
      n_checks++; if (out_word !== 16'h0000) $display("FAIL reset_out_word got %h want 0000", out_word); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] w = 16'hC933;
      out_ready = 1'b1;
      feed4(16'h93C3);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_first_valid got %b want 1", out_valid); else n_pass++;
      n_checks++; if (out_word !== w) $display("FAIL b2b_word got %h want %h", out_word, w); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (out_data !== pick(w, k) || out_valid !== 1'b1)
            $display("FAIL b2b_drain%0d got %h/%b want %h/1", k, out_data, out_valid, pick(w, k));
         else n_pass++;
         n_checks++; if (out_word !== w) $display("FAIL b2b_word_hold%0d got %h want %h", k, out_word, w); else n_pass++;
         tick();
      end
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || fill !== 3'd0)
         $display("FAIL b2b_end got v=%b r=%b f=%0d want v=0 r=1 f=0", out_valid, in_ready, fill);
      else n_pass++;
      out_ready = 1'b0;
   endtask

   task automatic test_gaps_stall();
      logic [15:0] w = 16'hFEDC;
      logic [15:0] beats = 16'hFEDC;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_data = beats[4*(3-k) +: 4]; in_valid = 1'b1;
         tick();
         in_data = 4'h1; in_valid = 1'b0;
         if (k < 3) begin
            tick();
            n_checks++; if (fill !== 3'(k+1)) $display("FAIL gap_fill%0d got %0d want %0d", k, fill, k+1); else n_pass++;
         end
      end
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== pick(w, 0))
            $display("FAIL stall_hold%0d got %h/%b want %h/1", c, out_data, out_valid, pick(w, 0));
         else n_pass++;
         tick();
      end
      n_checks++; if (out_word !== w) $display("FAIL gap_word got %h want %h", out_word, w); else n_pass++;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (out_data !== pick(w, k) || fill !== 3'(4-k))
            $display("FAIL gap_drain%0d got d=%h f=%0d want d=%h f=%0d", k, out_data, fill, pick(w, k), 4-k);
         else n_pass++;
         tick();
      end
      n_checks++; if (fill !== 3'd0) $display("FAIL gap_fill_end got %0d want 0", fill); else n_pass++;
      out_ready = 1'b0;
   endtask

   task automatic test_zeros_block();
      out_ready = 1'b1;
      feed4(16'h0000);
      in_valid = 1'b1; in_data = 4'h5;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (in_ready !== 1'b0 || out_data !== 4'h0 || out_valid !== 1'b1)
            $display("FAIL zero_drain%0d got r=%b d=%h v=%b want r=0 d=0 v=1", k, in_ready, out_data, out_valid);
         else n_pass++;
         tick();
      end
      n_checks++; if (fill !== 3'd0 || in_ready !== 1'b1)
         $display("FAIL zero_no_accept_last got f=%0d r=%b want f=0 r=1", fill, in_ready);
      else n_pass++;
      tick();
      in_valid = 1'b0;
      n_checks++; if (fill !== 3'd1) $display("FAIL zero_next_accept got %0d want 1", fill); else n_pass++;
      out_ready = 1'b0;
      do_reset();
   endtask

   task automatic test_mid_reset();
      logic [15:0] w = 16'h8742;
      in_data = 4'h5; in_valid = 1'b1; tick();
      in_data = 4'h1; tick();
      in_valid = 1'b0;
      n_checks++; if (fill !== 3'd2) $display("FAIL mid_fill_pre got %0d want 2", fill); else n_pass++;
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++; if (fill !== 3'd0 || out_valid !== 1'b0)
         $display("FAIL mid_reset_state got f=%0d v=%b want f=0 v=0", fill, out_valid);
      else n_pass++;
      feed4(16'h7284);
      n_checks++; if (out_word !== w) $display("FAIL mid_word got %h want %h", out_word, w); else n_pass++;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (out_data !== pick(w, k)) $display("FAIL mid_drain%0d got %h want %h", k, out_data, pick(w, k));
         else n_pass++;
         tick();
      end
      out_ready = 1'b0;
      feed4(16'h1234);
      rst = 1'b1; tick(); rst = 1'b0;
      n_checks++; if (out_valid !== 1'b0 || fill !== 3'd0 || out_word !== 16'h0000 || in_ready !== 1'b1)
         $display("FAIL drain_reset got v=%b f=%0d w=%h r=%b want v=0 f=0 w=0000 r=1", out_valid, fill, out_word, in_ready);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps_stall();
      test_zeros_block();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/nibble_stream_sorter.md
NIBBLE_STREAM_SORTER -- requirements
Module: nibble_stream_sorter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_data, input, 4 bits: unsigned nibble to be sorted.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-006 SHALL have port out_data, output, 4 bits: current sorted nibble being drained.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer takes out_data this cycle.
REQ-009 SHALL have port out_word, output, 16 bits: full sorted frame, largest in [15:12], smallest in [3:0]; valid only while out_valid=1.
REQ-010 SHALL have port fill, output, 3 bits: number of nibbles held (0..4).

Function
REQ-011 SHALL process frames of exactly 4 nibbles, using a two-state FSM: LOAD, DRAIN.
REQ-012 In LOAD, the block SHALL drive in_ready=1 and out_valid=0; an input beat is accepted when in_valid and in_ready are both 1.
REQ-013 On each accepted beat, the block SHALL insert in_data into a 4-slot ascending buffer in one cycle by shifting larger entries up; equal values SHALL be placed after existing equal entries (stable).
REQ-014 On the 4th accepted beat, the FSM SHALL move to DRAIN on the next edge; first out_valid=1 one cycle after the 4th accept.
REQ-015 In DRAIN, the block SHALL drive in_ready=0 and out_valid=1; out_data SHALL be slot 0 (the smallest remaining entry).
REQ-016 On each out_ready with out_valid, the buffer SHALL shift down one slot and fill SHALL decrement.
REQ-017 out_data and out_valid SHALL hold stable while out_ready=0.
REQ-018 out_word SHALL show the frame as captured at entry to DRAIN and SHALL not change during the drain.
REQ-019 On the last drain beat (fill=1 and out_ready=1), the FSM SHALL return to LOAD with fill=0; no input is accepted in that same cycle.
REQ-020 in_valid during DRAIN SHALL be ignored; out_ready during LOAD SHALL be ignored.
REQ-021 Comparisons SHALL be unsigned 4-bit; no widening or saturation.

Reset
REQ-022 While rst=1 on an edge: state=LOAD, fill=0, all slots=0, out_valid=0, in_ready=1 after release, out_data=0, out_word=0.
REQ-023 Reset mid-frame (LOAD or DRAIN) SHALL discard all held nibbles; the next accepted beat starts a new frame.

Configuration
REQ-024 With macro NIBBLE_SORTER_DESC_EN defined, the drain order SHALL be descending (largest first) and stable ordering of equal values SHALL be kept; out_word layout SHALL be unchanged.
REQ-025 Without NIBBLE_SORTER_DESC_EN, the drain order SHALL be ascending per REQ-015.

Structure
REQ-026 A shared package nibble_sorter_pkg SHALL hold nibble_t (4-bit), the constant FRAME_LEN=4, and the state enum {LOAD, DRAIN}.
REQ-027 The block SHALL have one sub-module, sort_slot, which holds one nibble and selects hold, take-input, or take-lower-neighbour based on the compare result.

Verification
REQ-028 Feed 9,3,C,3 back-to-back with out_ready=1 -> out_data 3,3,9,C on consecutive cycles starting 1 cycle after the 4th accept; out_word=16'hC933.
REQ-029 Feed F,E,D,C with in_valid gaps; hold out_ready=0 for 3 cycles -> out_valid=1, out_data=C held stable; then drain C,D,E,F; fill steps 4,3,2,1,0.
REQ-030 Feed 0,0,0,0 -> drain 0,0,0,0; in_ready=0 throughout DRAIN even with in_valid=1; next frame accepted only after the last drain beat.
REQ-031 Accept 2 nibbles (5,1), assert rst for 1 cycle, then feed 7,2,8,4 -> drain 2,4,7,8; fill=0 immediately after reset.
REQ-032 With NIBBLE_SORTER_DESC_EN defined, feed 9,3,C,3 -> drain C,9,3,3; out_word=16'hC933.
